// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU data-memory request/response interface.
package cpu_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mem_word_array.sv
// Word array with per-byte synchronous write and registered synchronous read.
// Storage and read register are deliberately not reset.
module mem_word_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Byte-masked write and read capture on the same access edge
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (rd_en_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Responder for CPU data-memory requests: one outstanding request, fixed
// programmable latency from accept to response, byte-enabled stores.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int       AW       = $clog2(DEPTH_WORDS);
  localparam bit [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              rdy_q, vld_q, we_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [31:0]       off;
  logic              req_err;
  logic              access, wr_en, rd_en;
  logic [WORD_W-1:0] mem_rdata;

  // Address decode on the incoming request; index truncation is safe once in range
  assign off     = req_addr - BASE_ADDR;
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                   ((off >> 2) >= DEPTH_WORDS);

  // The counter reaching zero in WAIT marks the edge that enters RESP, so the
  // array is touched exactly LATENCY edges after accept. Errored accesses are squashed.
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign wr_en  = access &  we_q & ~err_q;
  assign rd_en  = access & ~we_q & ~err_q;

  // Request/response FSM with latency counter and request latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (req_valid && rdy_q) begin
            we_q    <= req_we;
            err_q   <= req_err;
            idx_q   <= off[AW+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt_q   <= CNT_INIT;
            rdy_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_word_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (CLK),
    .wr_en_i (wr_en),
    .rd_en_i (rd_en),
    .addr_i  (idx_q),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Read register only holds meaningful data for a good load in RESP
  assign req_ready  = rdy_q;
  assign resp_valid = vld_q;
  assign resp_err   = vld_q & err_q;
  assign resp_rdata = (vld_q && !we_q && !err_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) on a shared clock/reset.
module tb_data_mem_responder;
  localparam int N = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [N-1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [N-1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [N-1:0][3:0]  req_be;

  int lat_of [N] = '{2, 1, 15};
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS (512),
      .LATENCY     (g == 0 ? 2 : (g == 1 ? 1 : 15)),
      .BASE_ADDR   (32'h0)
    ) u_dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_be     (req_be[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; optional stall of resp_ready with junk request driven meanwhile
  task automatic xfer(input int d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int hold,
                      input string tag, input logic [31:0] exp_rd, input bit exp_err);
    int n;
    @(negedge CLK);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_be[d]    = be;
    @(posedge CLK);
    #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (resp_valid[d] === 1'b1) break;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat_of[d]));
    if (hold > 0) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'hF;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK);
      #1;
      chk({tag, "_hold_vld"}, 32'(resp_valid[d]), 32'd1);
      chk({tag, "_hold_rd"}, resp_rdata[d], exp_rd);
      chk({tag, "_hold_rdy"}, 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    chk({tag, "_rdata"}, resp_rdata[d], exp_rd);
    chk({tag, "_err"}, 32'(resp_err[d]), 32'(exp_err));
    resp_ready[d] = 1'b1;
    @(posedge CLK);
    #1;
    resp_ready[d] = 1'b0;
    chk({tag, "_vld_off"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = '0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(req_ready[0]), 32'd0);
    chk("rst_vld",   32'(resp_valid[0]), 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'd0);
    chk("rst_err",   32'(resp_err[0]), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst_ready", 32'(req_ready[0]), 32'd1);

    // full-word store then load
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "t1_st", 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0,        4'hF, 0, "t1_ld", 32'hDEADBEEF, 1'b0);
    // single-byte merge
    xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, "t2_st", 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0,        4'hF, 0, "t2_ld", 32'hDEADBEAA, 1'b0);
    // misaligned and out-of-range: errors, no array change
    xfer(0, 1'b0, 32'h12,  32'h0,        4'hF, 0, "t3_ld_mis", 32'h0, 1'b1);
    xfer(0, 1'b1, 32'h12,  32'h11111111, 4'hF, 0, "t3_st_mis", 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h10,  32'h0,        4'hF, 0, "t3_ld_chk", 32'hDEADBEAA, 1'b0);
    xfer(0, 1'b1, 32'h0,   32'h12345678, 4'hF, 0, "t3_st_w0", 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h800, 32'h0,        4'hF, 0, "t3_ld_oor", 32'h0, 1'b1);
    xfer(0, 1'b1, 32'h800, 32'h22222222, 4'hF, 0, "t3_st_oor", 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0,   32'h0,        4'hF, 0, "t3_ld_w0", 32'h12345678, 1'b0);
    // zero byte-enable store leaves data alone
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, "be0_st", 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0,        4'hF, 0, "be0_ld", 32'hDEADBEAA, 1'b0);
    // stalled response; junk store presented during the stall must be ignored
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, "t4_hold", 32'hDEADBEAA, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, "t4_after", 32'hDEADBEAA, 1'b0);

    // reset while a store is waiting
    @(negedge CLK);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h55555555; req_be[0] = 4'hF;
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_rdy", 32'(req_ready[0]), 32'd0);
    chk("t5_vld", 32'(resp_valid[0]), 32'd0);
    chk("t5_rd",  resp_rdata[0], 32'd0);
    chk("t5_err", 32'(resp_err[0]), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, "t5_ld", 32'hDEADBEAA, 1'b0);

    // two-byte scattered store
    xfer(0, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hA, 0, "pbe_st", 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0,        4'hF, 0, "pbe_ld", 32'hA5ADA5AA, 1'b0);

    // latency extremes
    xfer(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, "l1_st", 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h20, 32'h0,        4'hF, 0, "l1_ld", 32'hCAFEF00D, 1'b0);
    xfer(2, 1'b1, 32'h7FC, 32'h0BADC0DE, 4'hF, 0, "l15_st", 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h7FC, 32'h0,        4'hF, 0, "l15_ld", 32'h0BADC0DE, 1'b0);
    xfer(2, 1'b0, 32'h7FD, 32'h0,        4'hF, 0, "l15_mis", 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
